lfsr_sequence_controller: RTL and testbench

Sequences a parameterizable Fibonacci LFSR (lfsr_core) on behalf of one consumer. Accepts seed loads and burst requests ("give me N values"), then streams exactly N LFSR states over a valid/ready output channel, advancing the register only on accepted transfers. Flags completion of a full period and rejects the all-zero lock-up seed. It sits between the control logic and the pseudo-random sequence generator, replacing free-running clocking of the register.

---
 rtl/lfsr_pkg.sv | 49 ++++
 rtl/lfsr_core.sv | 37 +++
 rtl/lfsr_sequence_controller.sv | 119 +++++++++++
 tb/tb_lfsr_sequence_controller.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and helpers for the LFSR sequencing block.
//   state_t      controller FSM states
//   LFSR_MAX_W   widest register the helpers support
//   default_taps maximal-length Fibonacci tap mask for a given width
//   next_state   one Fibonacci step: shift left, XOR of tapped bits into bit 0
package lfsr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int LFSR_MAX_W = 32;

  // Tap masks are written for the shift-left form used by next_state
  // (feedback = XOR of tapped bits). Widths without an entry return zero
  // and must be given explicit taps by the instantiating block.
  function automatic logic [LFSR_MAX_W-1:0] default_taps(input int width);
    logic [LFSR_MAX_W-1:0] taps;
    case (width)
      2:       taps = 32'h0000_0003;
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      16:      taps = 32'h0000_D008;
      default: taps = '0;
    endcase
    return taps;
  endfunction

  // Caller passes a zero-extended register; bits at or above width are
  // cleared so the result can be truncated back to the register width.
  function automatic logic [LFSR_MAX_W-1:0] next_state(
    input logic [LFSR_MAX_W-1:0] lfsr,
    input logic [LFSR_MAX_W-1:0] taps,
    input int                    width
  );
    logic [LFSR_MAX_W-1:0] nxt;
    nxt = {lfsr[LFSR_MAX_W-2:0], ^(lfsr & taps)};
    for (int i = 0; i < LFSR_MAX_W; i++) begin
      if (i >= width) nxt[i] = 1'b0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci LFSR register with load and single-step control.
//   clock     rising-edge clock
//   reset     synchronous active-high; register returns to SEED
//   load      replace register with load_val (priority over step)
//   load_val  value to load
//   step      advance one state
//   q         current register value
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_nxt;

  assign q_nxt = WIDTH'(next_state(LFSR_MAX_W'(q), LFSR_MAX_W'(TAPS), WIDTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= SEED;
    end else if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/lfsr_sequence_controller.sv
// lfsr_sequence_controller: streams bursts of LFSR states over valid/ready.
//   clock, reset   rising-edge clock, synchronous active-high reset
//   seed_valid/_data  seed load, honoured in IDLE; zero seed is replaced by SEED
//   req_valid/_count  burst request for req_count values (0 = no-op)
//   req_ready      IDLE and not in reset
//   out_valid/_data/_ready  output channel; LFSR advances only on transfers
//   busy           burst in progress
//   period_done    pulse after a transfer whose successor equals the burst start
//   lockup         pulse after a zero seed was rejected
//
// state | meaning
// IDLE  | accepting seeds and burst requests, output channel empty
// RUN   | presenting LFSR states until the requested count is transferred
module lfsr_sequence_controller
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               CW    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed_data,
  input  logic             req_valid,
  input  logic [CW-1:0]    req_count,
  output logic             req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             period_done,
  output logic             lockup
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lfsr, lfsr_nxt;
  logic [WIDTH-1:0] seed_eff, start_eff, start_val;
  logic [CW-1:0]    remaining;
  logic             seed_in_idle, burst_start, fire, last_beat;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clock    (clock),
    .reset    (reset),
    .load     (seed_in_idle),
    .load_val (seed_eff),
    .step     (fire),
    .q        (lfsr)
  );

  assign lfsr_nxt = WIDTH'(next_state(LFSR_MAX_W'(lfsr), LFSR_MAX_W'(TAPS), WIDTH));

  // A seed arriving with a request takes effect first, so the burst start
  // value is the seed (or its recovery value) rather than the old register.
  always_comb begin
    seed_in_idle = (state == IDLE) && seed_valid;
    seed_eff     = (seed_data != '0) ? seed_data : SEED;
    start_eff    = seed_in_idle ? seed_eff : lfsr;
    burst_start  = req_ready && req_valid && (req_count != '0);
    fire         = (state == RUN) && out_valid && out_ready;
    last_beat    = fire && (remaining == CW'(1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (burst_start) state_nxt = RUN;
      RUN:     if (last_beat)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RUN);
    req_ready = (state == IDLE) && !reset;
  end

  // Remaining exits RUN at 1, so the decrement never wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      remaining   <= '0;
      start_val   <= SEED;
      out_valid   <= 1'b0;
      out_data    <= '0;
      period_done <= 1'b0;
      lockup      <= 1'b0;
    end else begin
      lockup      <= seed_in_idle && (seed_data == '0);
      period_done <= fire && (lfsr_nxt == start_val);
      if (burst_start) begin
        remaining <= req_count;
        start_val <= start_eff;
        out_valid <= 1'b1;
        out_data  <= start_eff;
      end else if (fire) begin
        remaining <= remaining - CW'(1);
        if (last_beat) begin
          out_valid <= 1'b0;
        end else begin
          out_data <= lfsr_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_sequence_controller.sv
module tb_lfsr_sequence_controller;

  logic       clock;
  logic       reset;
  logic       seed_valid;
  logic [2:0] seed_data;
  logic       req_valid;
  logic [7:0] req_count;
  logic       req_ready;
  logic       out_valid;
  logic [2:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       period_done;
  logic       lockup;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_q[$];
  logic [2:0] m_lfsr;

  lfsr_sequence_controller #(
    .WIDTH (3),
    .TAPS  (3'b110),
    .SEED  (3'b001),
    .CW    (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .seed_valid  (seed_valid),
    .seed_data   (seed_data),
    .req_valid   (req_valid),
    .req_count   (req_count),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .period_done (period_done),
    .lockup      (lockup)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          rst;
    bit          sv;
    logic [2:0]  sd;
    logic [7:0]  cnt;
    logic [15:0] rdy;
    bit          rsv;
    logic [2:0]  rsd;
    int          n;
    logic [23:0] v;
    int          per;
    int          lck;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Shift left, new bit 0 = parity of bits 2 and 1.
  function automatic logic [2:0] mstep(input logic [2:0] v);
    int p;
    p = $countones(v & 3'b110);
    return {v[1:0], p[0]};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    seed_valid = 1'b0;
    req_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Starts at posedge+1 with the DUT idle; returns at posedge+1, idle.
  task automatic run_burst(input bit sv, input logic [2:0] sd, input logic [7:0] cnt,
                           input logic [15:0] rdy, input bit rsv, input logic [2:0] rsd,
                           input int exp_per, input int exp_lck, input string nm);
    logic [2:0] obs[$];
    int         per_seen;
    int         lck_seen;
    bit         held_v;
    logic [2:0] held;
    bit         done;
    int         lim;
    per_seen = 0;
    lck_seen = 0;
    held_v   = 0;
    held     = '0;
    done     = 0;
    seed_valid = sv;
    seed_data  = sd;
    req_valid  = 1'b1;
    req_count  = cnt;
    out_ready  = 1'b0;
    @(posedge clock);
    #1;
    seed_valid = rsv;
    seed_data  = rsd;
    req_valid  = 1'b0;
    req_count  = '0;
    for (int k = 0; k < 200; k++) begin
      out_ready = (k < 16) ? rdy[k[3:0]] : 1'b1;
      @(negedge clock);
      per_seen += int'(period_done);
      lck_seen += int'(lockup);
      if (held_v && out_valid) check({nm, "_hold"}, int'(out_data), int'(held));
      held_v = 0;
      if (out_valid && out_ready) obs.push_back(out_data);
      else if (out_valid) begin
        held_v = 1;
        held   = out_data;
      end
      if (!busy) begin
        done = 1;
        break;
      end
      @(posedge clock);
      #1;
    end
    seed_valid = 1'b0;
    out_ready  = 1'b0;
    if (!done) begin
      bad++;
      total++;
      $display("FAIL %s_timeout actual=busy required=idle", nm);
    end
    check({nm, "_len"}, obs.size(), exp_q.size());
    lim = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < lim; i++)
      check($sformatf("%s_val%0d", nm, i), int'(obs[i]), int'(exp_q[i]));
    check({nm, "_period"}, per_seen, exp_per);
    check({nm, "_lockup"}, lck_seen, exp_lck);
    check({nm, "_req_ready"}, int'(req_ready), 1);
    check({nm, "_out_valid"}, int'(out_valid), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit         sv, rsv, lck;
    logic [2:0] sd, rsd, start, v;
    logic [7:0] cnt;
    logic [15:0] rdy;
    int         per;

    reset = 1'b1;
    seed_valid = 1'b0;
    seed_data = '0;
    req_valid = 1'b0;
    req_count = '0;
    out_ready = 1'b0;

    tbl[0]  = '{1'b1, 1'b0, 3'd0, 8'd7, 16'hFFFF, 1'b0, 3'd0, 7, 24'o12537640, 1, 0};
    tbl[1]  = '{1'b0, 1'b1, 3'd5, 8'd3, 16'hFFFF, 1'b0, 3'd0, 3, 24'o53700000, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 3'd0, 8'd1, 16'hFFFF, 1'b0, 3'd0, 1, 24'o60000000, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 3'd0, 8'd0, 16'hFFFF, 1'b0, 3'd0, 0, 24'o00000000, 0, 1};
    tbl[4]  = '{1'b0, 1'b0, 3'd0, 8'd2, 16'hFFFF, 1'b0, 3'd0, 2, 24'o12000000, 0, 0};
    tbl[5]  = '{1'b1, 1'b0, 3'd0, 8'd4, 16'hFFD9, 1'b0, 3'd0, 4, 24'o12530000, 0, 0};
    tbl[6]  = '{1'b0, 1'b0, 3'd0, 8'd0, 16'hFFFF, 1'b0, 3'd0, 0, 24'o00000000, 0, 0};
    tbl[7]  = '{1'b1, 1'b0, 3'd0, 8'd3, 16'hFFFF, 1'b1, 3'd7, 3, 24'o12500000, 0, 0};
    tbl[8]  = '{1'b0, 1'b0, 3'd0, 8'd2, 16'hFFFF, 1'b1, 3'd0, 2, 24'o37000000, 0, 0};
    tbl[9]  = '{1'b0, 1'b1, 3'd3, 8'd8, 16'hA5A5, 1'b0, 3'd0, 8, 24'o37641253, 1, 0};
    tbl[10] = '{1'b0, 1'b1, 3'd0, 8'd2, 16'hFFFF, 1'b0, 3'd0, 2, 24'o12000000, 0, 1};

    // Outputs during reset, then ready once released.
    @(posedge clock);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_period", int'(period_done), 0);
    check("rst_lockup", int'(lockup), 0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    check("idle_req_ready", int'(req_ready), 1);
    check("idle_busy", int'(busy), 0);
    @(posedge clock);
    #1;

    for (int t = 0; t < 11; t++) begin
      if (tbl[t].rst) do_reset();
      exp_q.delete();
      for (int i = 0; i < tbl[t].n; i++) exp_q.push_back(tbl[t].v[21-3*i +: 3]);
      run_burst(tbl[t].sv, tbl[t].sd, tbl[t].cnt, tbl[t].rdy, tbl[t].rsv, tbl[t].rsd,
                tbl[t].per, tbl[t].lck, $sformatf("t%0d", t));
    end

    // Reset after two transfers of a seven-value burst.
    do_reset();
    req_valid = 1'b1;
    req_count = 8'd7;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    check("mid_val0", int'(out_data), 1);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("mid_val1", int'(out_data), 2);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    check("mid_out_valid", int'(out_valid), 0);
    check("mid_busy", int'(busy), 0);
    check("mid_out_data", int'(out_data), 0);
    check("mid_req_ready", int'(req_ready), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    exp_q.push_back(3'd1);
    run_burst(1'b0, 3'd0, 8'd1, 16'hFFFF, 1'b0, 3'd0, 0, 0, "mid_after");

    // Random bursts against the sequence model.
    do_reset();
    m_lfsr = 3'd1;
    for (int b = 0; b < 40; b++) begin
      sv  = ($urandom_range(0, 2) == 0);
      sd  = 3'($urandom_range(0, 7));
      cnt = 8'($urandom_range(0, 20));
      rdy = 16'($urandom);
      rsv = ($urandom_range(0, 3) == 0);
      rsd = 3'($urandom_range(0, 7));
      lck = 0;
      if (sv) begin
        lck = (sd == 3'd0);
        m_lfsr = (sd == 3'd0) ? 3'd1 : sd;
      end
      start = m_lfsr;
      v = m_lfsr;
      per = 0;
      exp_q.delete();
      for (int i = 0; i < int'(cnt); i++) begin
        exp_q.push_back(v);
        v = mstep(v);
        if (v == start) per++;
      end
      m_lfsr = v;
      run_burst(sv, sd, cnt, rdy, rsv, rsd, per, int'(lck), $sformatf("r%0d", b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
